// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_stage and fetch_skid_buffer.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register.
// Catches a fetch response that arrives while decode is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_pc,
    input  logic            rst_pc,
    input  logic            wr_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [31:0]     wr_instr_i,
    input  logic            rd_i,
    input  logic            clr_i,
    output logic            full_o,
    output logic [XLEN-1:0] rd_pc_o,
    output logic [31:0]     rd_instr_o
);

    logic            full_q, full_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (wr_i) begin
            full_d  = 1'b1;
            pc_d    = wr_pc_i;
            instr_d = wr_instr_i;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_pc or negedge rst_pc) begin
        if (!rst_pc) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o     = full_q;
    assign rd_pc_o    = pc_q;
    assign rd_instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC logic, imem request FSM, one-entry skid buffer and IF/ID register.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned redirect targets into faulting NOPs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk_pc,
    input  logic            rst_pc,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [31:0]     ifid_instr_o,
    output logic            ifid_fault_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            pending_drop_q, pending_drop_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;

    logic            req_fire, rsp_deliver;
    logic            redirect_bad, halt;
    logic [XLEN-1:0] redirect_target;

    logic            buf_wr, buf_rd, buf_clr, buf_full;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d, halt_q, halt_d;

    assign redirect_bad    = redirect_i & (|redirect_pc_i[1:0]);
    assign redirect_target = redirect_pc_i;

    // A misaligned target parks the FSM until a later redirect supplies a good address.
    always_comb begin
        halt_d  = halt_q;
        fault_d = fault_q;
        if (redirect_i) begin
            halt_d  = redirect_bad;
            fault_d = redirect_bad;
        end else if (!stall_i) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk_pc or negedge rst_pc) begin
        if (!rst_pc) begin
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            halt_q  <= halt_d;
            fault_q <= fault_d;
        end
    end

    assign halt         = halt_q;
    assign ifid_fault_o = fault_q;
`else
    assign redirect_bad    = 1'b0;
    assign redirect_target = redirect_pc_i & ~XLEN'(3);
    assign halt            = 1'b0;
    assign ifid_fault_o    = 1'b0;
`endif

    assign imem_req_valid_o = (state_q == REQ);
    assign imem_addr_o      = addr_q;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;
    assign rsp_deliver      = (state_q == WAIT) & imem_rsp_valid_i;

    // PC was already moved to the redirect target while a drop is pending; do not step it.
    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i) begin
            pc_next_o = redirect_target;
        end else if (req_fire && !pending_drop_q) begin
            pc_next_o = pc_i + XLEN'(PC_STEP);
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        pending_drop_d = pending_drop_q;
        unique case (state_q)
            IDLE: begin
                // pc_i is stale during a redirect cycle; capture it on the next one.
                if (!buf_full && !redirect_i && !halt) begin
                    addr_d  = pc_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_fire) begin
                    state_d        = (redirect_i || pending_drop_q) ? DROP : WAIT;
                    pending_drop_d = 1'b0;
                end else if (redirect_i) begin
                    pending_drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    // A response coinciding with a redirect is already the one to discard.
                    if (redirect_i || stall_i) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = pc_i;
                        state_d = REQ;
                    end
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        buf_wr       = 1'b0;
        buf_rd       = 1'b0;
        buf_clr      = 1'b0;
        if (redirect_i) begin
            buf_clr      = 1'b1;
            ifid_valid_d = redirect_bad;
            if (redirect_bad) begin
                ifid_pc_d    = redirect_target;
                ifid_instr_d = NOP_INSTR;
            end
        end else if (!stall_i) begin
            if (buf_full) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = buf_pc;
                ifid_instr_d = buf_instr;
                buf_rd       = 1'b1;
            end else if (rsp_deliver) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = addr_q;
                ifid_instr_d = imem_rsp_data_i;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end else if (rsp_deliver) begin
            buf_wr = 1'b1;
        end
    end

    always_ff @(posedge clk_pc or negedge rst_pc) begin
        if (!rst_pc) begin
            state_q        <= IDLE;
            addr_q         <= RESET_VECTOR;
            pending_drop_q <= 1'b0;
            ifid_valid_q   <= 1'b0;
            ifid_pc_q      <= '0;
            ifid_instr_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            pending_drop_q <= pending_drop_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_instr_q   <= ifid_instr_d;
        end
    end

    fetch_skid_buffer #(
        .XLEN (XLEN)
    ) u_skid (
        .clk_pc     (clk_pc),
        .rst_pc     (rst_pc),
        .wr_i       (buf_wr),
        .wr_pc_i    (addr_q),
        .wr_instr_i (imem_rsp_data_i),
        .rd_i       (buf_rd),
        .clr_i      (buf_clr),
        .full_o     (buf_full),
        .rd_pc_o    (buf_pc),
        .rd_instr_o (buf_instr)
    );

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;

endmodule
